imem_boot_loader: RTL and testbench

Boot-time controller that owns the write side of the instruction memory and holds the CPU until a program image has been loaded.
- On `start`, it first clears every word to NOP (32'h0000_0000).
- It then accepts a little-endian byte stream over a valid/ready handshake, assembles 32-bit words and writes them from word 0 upward.
- Finally it asserts `cpu_run` to release the fetch stage.
- Sits between the off-chip/testbench program source and the instruction memory write port.

---
 rtl/imem_pkg.sv | 30 +++
 rtl/imem_boot_loader_packer.sv | 51 +++++
 rtl/imem_boot_loader.sv | 150 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module : imem_pkg
// Brief  : Shared constants for the instruction memory and its boot loader:
//          loader state encodings, the NOP word, the default memory depth and
//          a word-index to byte-address helper.
// Rev    : 1.0  initial release
// ============================================================================
package imem_pkg;

  // Default instruction memory depth in 32-bit words
  localparam int DEF_SIZE = 128;

  // Cleared memory content: all-zero word executes as NOP
  localparam logic [31:0] NOP = 32'h0000_0000;

  // Loader FSM state encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERROR = 3'd4;

  // Word index to word-aligned byte address
  function automatic logic [31:0] word_addr(input logic [31:0] idx);
    return {idx[29:0], 2'b00};
  endfunction

endpackage : imem_pkg
`default_nettype wire

// File: rtl/imem_boot_loader_packer.sv
`default_nettype none
// ============================================================================
// Module : byte_word_packer
// Brief  : Little-endian byte-to-word assembler. Tracks the byte position,
//          keeps the first three bytes of the word, presents the completed
//          word alongside the fourth byte and pulses o_word_ready for one
//          cycle after the fourth byte is taken.
// Rev    : 1.0  initial release
// ============================================================================
module byte_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_take,
  input  logic [7:0]  i_byte,
  output logic        o_last,
  output logic [31:0] o_word_next,
  output logic        o_word_ready
);

  logic [1:0]  r_cnt;
  logic [23:0] r_asm;
  logic        r_word_ready;

  // Byte position counter, partial-word assembly and completion pulse
  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_cnt        <= 2'd0;
      r_asm        <= 24'd0;
      r_word_ready <= 1'b0;
    end else begin
      r_word_ready <= i_take && (r_cnt == 2'd3);
      if (i_take) begin
        case (r_cnt)
          2'd0:    r_asm[7:0]   <= i_byte;
          2'd1:    r_asm[15:8]  <= i_byte;
          2'd2:    r_asm[23:16] <= i_byte;
          default: r_asm        <= r_asm;
        endcase
        r_cnt <= r_cnt + 2'd1;
      end
    end
  end

  // The fourth byte completes the word directly from the input
  assign o_last       = (r_cnt == 2'd3);
  assign o_word_next  = {i_byte, r_asm};
  assign o_word_ready = r_word_ready;

endmodule : byte_word_packer
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module : imem_boot_loader
// Brief  : Boot-time owner of the instruction memory write port. Clears the
//          memory to NOP, streams a little-endian byte image into words 0..N-1
//          and then releases the CPU via o_cpu_run.
// Rev    : 1.0  initial release
// ============================================================================
module imem_boot_loader
  import imem_pkg::*;
#(
  parameter int SIZE = DEF_SIZE,
  parameter int AW   = $clog2(SIZE)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [AW:0] i_n_words,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte_data,
  output logic        o_byte_ready,
  output logic        o_mem_we,
  output logic [31:0] o_mem_waddr,
  output logic [31:0] o_mem_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_cpu_run
);

  localparam logic [AW:0] c_max_words = (AW+1)'(SIZE);
  localparam logic [AW:0] c_last_idx  = (AW+1)'(SIZE - 1);

  logic [2:0]  r_state;
  logic [AW:0] r_idx;
  logic [AW:0] r_n_words;
  logic        r_byte_ready;
  logic        r_mem_we;
  logic [31:0] r_mem_waddr;
  logic [31:0] r_mem_wdata;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic        r_cpu_run;

  logic        w_accept;
  logic        w_bad_len;
  logic        w_take;
  logic        w_last;
  logic [31:0] w_word_next;
  logic        w_word_ready;
  logic [AW:0] w_idx_inc;

  // Start is honoured only while no clear/load is running
  assign w_accept  = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                 (r_state == ST_ERROR));
  assign w_bad_len = (i_n_words == '0) || (i_n_words > c_max_words);
  assign w_take    = i_byte_valid && r_byte_ready;
  assign w_idx_inc = r_idx + 1'b1;

  byte_word_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clr        (w_accept),
    .i_take       (w_take),
    .i_byte       (i_byte_data),
    .o_last       (w_last),
    .o_word_next  (w_word_next),
    .o_word_ready (w_word_ready)
  );

  // Loader FSM: registered outputs are computed for the cycle being entered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_n_words    <= '0;
      r_byte_ready <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_waddr  <= 32'd0;
      r_mem_wdata  <= 32'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_cpu_run    <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        ST_CLEAR: begin
          if (r_idx == c_last_idx) begin
            r_state      <= ST_LOAD;
            r_idx        <= '0;
            r_byte_ready <= 1'b1;
          end else begin
            r_idx       <= w_idx_inc;
            r_mem_we    <= 1'b1;
            r_mem_waddr <= word_addr(32'(w_idx_inc));
          end
        end
        ST_LOAD: begin
          if (w_take && w_last) begin
            r_mem_we    <= 1'b1;
            r_mem_waddr <= word_addr(32'(r_idx));
            r_mem_wdata <= w_word_next;
            r_idx       <= w_idx_inc;
            // Stop accepting bytes once the final word is complete
            if (w_idx_inc == r_n_words) begin
              r_byte_ready <= 1'b0;
            end
          end else if (w_word_ready && (r_idx == r_n_words)) begin
            r_state   <= ST_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_cpu_run <= 1'b1;
          end
        end
        default: begin
          if (w_accept) begin
            r_done    <= 1'b0;
            r_cpu_run <= 1'b0;
            if (w_bad_len) begin
              r_state <= ST_ERROR;
              r_err   <= 1'b1;
            end else begin
              r_state     <= ST_CLEAR;
              r_err       <= 1'b0;
              r_n_words   <= i_n_words;
              r_idx       <= '0;
              r_busy      <= 1'b1;
              r_mem_we    <= 1'b1;
              r_mem_waddr <= 32'd0;
              r_mem_wdata <= NOP;
            end
          end
        end
      endcase
    end
  end

  assign o_byte_ready = r_byte_ready;
  assign o_mem_we     = r_mem_we;
  assign o_mem_waddr  = r_mem_waddr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_cpu_run    = r_cpu_run;

endmodule : imem_boot_loader
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_imem_boot_loader
// Brief  : Directed self-checking bench for imem_boot_loader (SIZE=8).
// Rev    : 1.0  initial release
// ============================================================================
module tb_imem_boot_loader;

  localparam int SIZE = 8;
  localparam int AW   = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [AW:0] i_n_words;
  logic        i_byte_valid;
  logic [7:0]  i_byte_data;
  logic        o_byte_ready;
  logic        o_mem_we;
  logic [31:0] o_mem_waddr;
  logic [31:0] o_mem_wdata;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic        o_cpu_run;

  int n_checks = 0;
  int n_err    = 0;

  logic [63:0] log_q[$];

  logic [7:0] img [8] = '{8'h13, 8'h00, 8'h08, 8'h20, 8'h01, 8'h00, 8'h09, 8'h21};

  imem_boot_loader #(.SIZE(SIZE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_n_words    (i_n_words),
    .i_byte_valid (i_byte_valid),
    .i_byte_data  (i_byte_data),
    .o_byte_ready (o_byte_ready),
    .o_mem_we     (o_mem_we),
    .o_mem_waddr  (o_mem_waddr),
    .o_mem_wdata  (o_mem_wdata),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_cpu_run    (o_cpu_run)
  );

  always #5 clk = ~clk;

  // Record every memory write as {addr, data}
  always @(negedge clk) begin
    if (o_mem_we === 1'b1) log_q.push_back({o_mem_waddr, o_mem_wdata});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_load(input logic [AW:0] n);
    i_start   = 1'b1;
    i_n_words = n;
    @(negedge clk);
    i_start   = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    i_byte_valid = 1'b1;
    i_byte_data  = b;
    while (o_byte_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("byte_ready_timeout", 32'(o_byte_ready), 32'd1);
    @(negedge clk);
    i_byte_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (o_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(o_done), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_we"},    32'(o_mem_we),     32'd0);
    check({tag, "_addr"},  o_mem_waddr,       32'd0);
    check({tag, "_data"},  o_mem_wdata,       32'd0);
    check({tag, "_busy"},  32'(o_busy),       32'd0);
    check({tag, "_done"},  32'(o_done),       32'd0);
    check({tag, "_err"},   32'(o_err),        32'd0);
    check({tag, "_run"},   32'(o_cpu_run),    32'd0);
    check({tag, "_ready"}, 32'(o_byte_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    i_start      = 1'b1;
    i_n_words    = 4'd1;
    i_byte_valid = 1'b0;
    i_byte_data  = 8'h00;

    // Reset held with start asserted
    repeat (2) @(negedge clk);
    check_idle_outputs("rst");
    i_start = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_rst");

    // Clear pass followed by a one-word load
    log_q.delete();
    start_load(4'd1);
    for (int i = 0; i < SIZE; i++) begin
      check("clr_we",    32'(o_mem_we),     32'd1);
      check("clr_addr",  o_mem_waddr,       32'(i * 4));
      check("clr_data",  o_mem_wdata,       32'd0);
      check("clr_ready", 32'(o_byte_ready), 32'd0);
      check("clr_busy",  32'(o_busy),       32'd1);
      @(negedge clk);
    end
    check("clr_end_we", 32'(o_mem_we), 32'd0);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_done("w1_done");
    check("w1_nlog", 32'(log_q.size()), 32'd9);
    if (log_q.size() == 9) check("w1_word", log_q[8][31:0], 32'h4433_2211);

    // Normal two-word load, back-to-back bytes (restart from DONE)
    log_q.delete();
    start_load(4'd2);
    check("rs_run",  32'(o_cpu_run), 32'd0);
    check("rs_done", 32'(o_done),    32'd0);
    check("rs_we",   32'(o_mem_we),  32'd1);
    check("rs_addr", o_mem_waddr,    32'd0);
    for (int i = 0; i < 8; i++) send_byte(img[i]);
    wait_done("n_done");
    check("n_run",   32'(o_cpu_run),    32'd1);
    check("n_busy",  32'(o_busy),       32'd0);
    check("n_ready", 32'(o_byte_ready), 32'd0);
    check("n_nlog",  32'(log_q.size()), 32'd10);
    if (log_q.size() == 10) begin
      check("n_a0", log_q[8][63:32], 32'h0);
      check("n_d0", log_q[8][31:0],  32'h2008_0013);
      check("n_a1", log_q[9][63:32], 32'h4);
      check("n_d1", log_q[9][31:0],  32'h2109_0001);
    end
    i_byte_valid = 1'b1;
    i_byte_data  = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("n_extra_ready", 32'(o_byte_ready), 32'd0);
    end
    i_byte_valid = 1'b0;
    check("n_extra_nlog", 32'(log_q.size()), 32'd10);

    // Same image with 3 idle cycles between bytes
    log_q.delete();
    start_load(4'd2);
    for (int i = 0; i < 8; i++) begin
      send_byte(img[i]);
      repeat (3) @(negedge clk);
    end
    wait_done("g_done");
    check("g_nlog", 32'(log_q.size()), 32'd10);
    if (log_q.size() == 10) begin
      check("g_a0", log_q[8][63:32], 32'h0);
      check("g_d0", log_q[8][31:0],  32'h2008_0013);
      check("g_a1", log_q[9][63:32], 32'h4);
      check("g_d1", log_q[9][31:0],  32'h2109_0001);
    end

    // Illegal lengths: zero and SIZE+1
    log_q.delete();
    start_load(4'd0);
    check("z_err",  32'(o_err),     32'd1);
    check("z_done", 32'(o_done),    32'd0);
    check("z_run",  32'(o_cpu_run), 32'd0);
    check("z_busy", 32'(o_busy),    32'd0);
    start_load(4'd9);
    check("big_err", 32'(o_err), 32'd1);
    repeat (3) @(negedge clk);
    check("big_err_sticky", 32'(o_err), 32'd1);
    check("ill_nlog", 32'(log_q.size()), 32'd0);

    // Legal start from ERROR clears err and loads normally
    start_load(4'd1);
    check("rec_err",  32'(o_err),  32'd0);
    check("rec_busy", 32'(o_busy), 32'd1);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    wait_done("rec_done");
    check("rec_nlog", 32'(log_q.size()), 32'd9);
    if (log_q.size() == 9) begin
      check("rec_a", log_q[8][63:32], 32'h0);
      check("rec_d", log_q[8][31:0],  32'hDDCC_BBAA);
    end

    // Reset after 6 bytes of a two-word load
    log_q.delete();
    start_load(4'd2);
    for (int i = 0; i < 6; i++) send_byte(img[i]);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("mid_rst");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("mid_rst_after");
    check("mid_nlog", 32'(log_q.size()), 32'd9);
    if (log_q.size() == 9) begin
      check("mid_a0", log_q[8][63:32], 32'h0);
      check("mid_d0", log_q[8][31:0],  32'h2008_0013);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_imem_boot_loader
`default_nettype wire
